// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl
//   Interrupt controller between the OTTER board peripherals and the OTTER_MCU
//   INTR input. Each raw request is synchronised and edge detected, then
//   latched into a pending register. Pending bits are masked and the lowest
//   index wins. One INTR line is held until software acknowledges or cancels
//   the request. After that, a holdoff window forces INTR low.
//
//   Optional feature: define INTC_LEVEL_EN to add a per-source level-mode
//   register at LEVEL_AD. When the macro is undefined, every source is edge
//   mode and LEVEL_AD is not decoded.
//
// Ports
//   CLK         in   1      system clock, the only clock
//   RST         in   1      synchronous, active-high reset
//   IRQ_IN      in   N_SRC  raw interrupt requests, asynchronous to CLK
//   IOBUS_ADDR  in   32     MCU IO address
//   IOBUS_OUT   in   32     MCU IO write data
//   IOBUS_WR    in   1      MCU IO write strobe, one cycle per store
//   RD_DATA     out  32     read data, combinational from registers
//   RD_HIT      out  1      IOBUS_ADDR matches a register of this block
//   INTR        out  1      interrupt request to the MCU
//   DBG_STATE   out  2      current FSM state (debug observation)
//
// Register map
//   PEND_AD   R, write-1-to-clear. Set beats clear on the same bit.
//   MASK_AD   R/W enable mask.
//   CAUSE_AD  R {valid(31), 27'b0, cause[3:0]}. Any write acknowledges.
//   LEVEL_AD  R/W level select (INTC_LEVEL_EN only).
//
// Bus handshake
//   A write is a single cycle with IOBUS_WR=1. It takes effect at that
//   posedge, and a read in the following cycle shows the new value. No
//   back-pressure exists: every access completes in one cycle.
module otter_intr_ctrl #(
  parameter int          N_SRC       = 4,
  parameter int          SYNC_STAGES = 2,
  parameter int          HOLDOFF_CYC = 4,
  parameter logic [31:0] PEND_AD     = 32'h1130_0000,
  parameter logic [31:0] MASK_AD     = 32'h1134_0000,
  parameter logic [31:0] CAUSE_AD    = 32'h1138_0000,
  parameter logic [31:0] LEVEL_AD    = 32'h113C_0000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_SRC-1:0] IRQ_IN,
  input  logic [31:0]      IOBUS_ADDR,
  input  logic [31:0]      IOBUS_OUT,
  input  logic             IOBUS_WR,
  output logic [31:0]      RD_DATA,
  output logic             RD_HIT,
  output logic             INTR,
  output logic [1:0]       DBG_STATE
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ASSERT  = 2'd1;
  localparam logic [1:0] S_HOLDOFF = 2'd2;

  localparam int CW = $clog2(HOLDOFF_CYC + 1);

  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [1:0]       state_q, state_d;
  logic [3:0]       cause_q, cause_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [N_SRC-1:0] synced;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] wdata;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] cause_oh;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] level_sel;
  logic [3:0]       winner;
  logic             hit_pend, hit_mask, hit_cause;
  logic             wr_pend, wr_mask, wr_cause;
  logic             ack_ok, cancel;

  // Only the low N_SRC bits of the write data address a source.
  logic unused_wdata;
  assign unused_wdata = ^IOBUS_OUT[31:N_SRC];

  assign wdata     = IOBUS_OUT[N_SRC-1:0];
  assign hit_pend  = (IOBUS_ADDR == PEND_AD);
  assign hit_mask  = (IOBUS_ADDR == MASK_AD);
  assign hit_cause = (IOBUS_ADDR == CAUSE_AD);
  assign wr_pend   = IOBUS_WR && hit_pend;
  assign wr_mask   = IOBUS_WR && hit_mask;
  assign wr_cause  = IOBUS_WR && hit_cause;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign rise     = synced & ~prev_q;
  assign eligible = pend_q & mask_q;

`ifdef INTC_LEVEL_EN
  logic [N_SRC-1:0] level_q, level_d;
  logic             hit_level, wr_level;

  assign hit_level = (IOBUS_ADDR == LEVEL_AD);
  assign wr_level  = IOBUS_WR && hit_level;
  assign level_sel = level_q;

  always_comb begin
    level_d = level_q;
    if (wr_level) level_d = wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) level_q <= '0;
    else     level_q <= level_d;
  end
`else
  logic unused_level;
  assign unused_level = (IOBUS_ADDR == LEVEL_AD);
  assign level_sel    = '0;
`endif

  always_comb begin
    cause_oh = '0;
    for (int i = 0; i < N_SRC; i++) cause_oh[i] = (cause_q == i[3:0]);
  end

  // Scanning from the top down leaves the lowest set index in winner.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = i[3:0];
    end
  end

  assign ack_ok = wr_cause && (state_q == S_ASSERT);
  // A W1C that targets the committed source withdraws the request. This
  // happens even when a new edge on that source re-sets the pending bit in
  // the same cycle.
  assign cancel = wr_pend && (state_q == S_ASSERT) && |(wdata & cause_oh);

  always_comb begin
    clr = '0;
    if (wr_pend) clr = clr | wdata;
    if (ack_ok)  clr = clr | cause_oh;
    // A new edge beats a clear that lands on the same bit.
    pend_d = (pend_q & ~clr) | rise;
    // Level-mode bits follow the synchronised input. W1C and ack cannot
    // clear them while the input is high.
    for (int i = 0; i < N_SRC; i++) begin
      if (level_sel[i]) pend_d[i] = synced[i];
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (wr_mask) mask_d = wdata;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          state_d = S_ASSERT;
          cause_d = winner;
        end
      end
      S_ASSERT: begin
        // Mask changes are ignored here: the request is already committed.
        if (ack_ok || cancel) begin
          state_d = S_HOLDOFF;
          cnt_d   = CW'(HOLDOFF_CYC - 1);
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q  <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      state_q <= S_IDLE;
      cause_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], IRQ_IN};
      prev_q  <= synced;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  // INTR drops as soon as reset is applied, without waiting for the edge.
  assign INTR      = (state_q == S_ASSERT) && !RST;
  assign DBG_STATE = state_q;

  always_comb begin
    RD_DATA = '0;
    RD_HIT  = 1'b0;
    if (hit_pend) begin
      RD_HIT  = 1'b1;
      RD_DATA = {{(32 - N_SRC){1'b0}}, pend_q};
    end else if (hit_mask) begin
      RD_HIT  = 1'b1;
      RD_DATA = {{(32 - N_SRC){1'b0}}, mask_q};
    end else if (hit_cause) begin
      RD_HIT  = 1'b1;
      RD_DATA = {(state_q == S_ASSERT), 27'b0, cause_q};
    end
`ifdef INTC_LEVEL_EN
    else if (hit_level) begin
      RD_HIT  = 1'b1;
      RD_DATA = {{(32 - N_SRC){1'b0}}, level_q};
    end
`endif
  end

endmodule
